// File: rtl/mux2way16_arbiter.sv
// Two-requester round-robin burst arbiter driving a registered 16-bit shared bus.
// A grant holds until the burst ends with last, or until MAX_BURST beats force a release.
module mux2way16_arbiter #(
    parameter int MAX_BURST = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_valid,
    input  logic [15:0] a_data,
    input  logic        a_last,
    input  logic        b_valid,
    input  logic [15:0] b_data,
    input  logic        b_last,
    input  logic        out_ready,
    output logic        a_ready,
    output logic        b_ready,
    output logic        sel,
    output logic        out_valid,
    output logic [15:0] out_data,
    output logic        trunc
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_A,
        BUSY_B
    } state_t;

    localparam logic [4:0] BURST_MAX = 5'(MAX_BURST);

    state_t     state, state_nx;
    logic       rr, rr_nx;
    logic       sel_nx;
    logic       trunc_nx;
    logic [4:0] beat_cnt, cnt_nx;
    logic       xfer;
    logic       cur_last;

    always_comb begin
        a_ready  = (state == BUSY_A) && (!out_valid || out_ready);
        b_ready  = (state == BUSY_B) && (!out_valid || out_ready);
        xfer     = (a_valid && a_ready) || (b_valid && b_ready);
        cur_last = sel ? b_last : a_last;

        state_nx = state;
        rr_nx    = rr;
        sel_nx   = sel;
        cnt_nx   = beat_cnt;
        trunc_nx = 1'b0;

        case (state)
            IDLE: begin
                if (a_valid && (!b_valid || !rr)) begin
                    state_nx = BUSY_A;
                    sel_nx   = 1'b0;
                    cnt_nx   = '0;
                end else if (b_valid) begin
                    state_nx = BUSY_B;
                    sel_nx   = 1'b1;
                    cnt_nx   = '0;
                end
            end
            BUSY_A, BUSY_B: begin
                if (xfer) begin
                    cnt_nx = beat_cnt + 5'd1;
                    // A last on the final allowed beat is a normal end, not a truncation.
                    if (cur_last) begin
                        state_nx = IDLE;
                        rr_nx    = (state == BUSY_A);
                    end else if (beat_cnt + 5'd1 == BURST_MAX) begin
                        state_nx = IDLE;
                        rr_nx    = (state == BUSY_A);
                        trunc_nx = 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr        <= 1'b0;
            sel       <= 1'b0;
            beat_cnt  <= '0;
            trunc     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            state    <= state_nx;
            rr       <= rr_nx;
            sel      <= sel_nx;
            beat_cnt <= cnt_nx;
            trunc    <= trunc_nx;
            if (xfer) begin
                out_data  <= sel ? b_data : a_data;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux2way16_arbiter.sv
// Directed bench for mux2way16_arbiter: a per-cycle vector table plus stream-driven
// burst sequences checked against hand-computed beat orderings.
module tb_mux2way16_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic [15:0] a_data = '0, b_data = '0;
    logic        a_last = 1'b0, b_last = 1'b0;
    logic        out_ready = 1'b0;
    logic        a_ready, b_ready, sel, out_valid, trunc;
    logic [15:0] out_data;

    int total = 0;
    int bad = 0;

    mux2way16_arbiter #(.MAX_BURST(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_data(a_data), .a_last(a_last),
        .b_valid(b_valid), .b_data(b_data), .b_last(b_last),
        .out_ready(out_ready),
        .a_ready(a_ready), .b_ready(b_ready), .sel(sel),
        .out_valid(out_valid), .out_data(out_data), .trunc(trunc)
    );

    always #5 clk = ~clk;

    logic [15:0] got[$];
    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready) got.push_back(out_data);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        av;
        logic [15:0] ad;
        logic        al;
        logic        bv;
        logic [15:0] bd;
        logic        bl;
        logic        ordy;
        logic        ea;
        logic        eb;
        logic        es;
        logic        eov;
        logic [15:0] eod;
        logic        etr;
    } vec_t;

    vec_t vecs[7];

    logic [15:0] qa_d[$], qb_d[$];
    logic        qa_l[$], qb_l[$];
    logic [15:0] exp_q[$];
    int hold_err, b_early, stall_seen, trunc_n;
    logic [15:0] trunc_od;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        a_valid = 1'b0; b_valid = 1'b0; a_last = 1'b0; b_last = 1'b0;
        a_data = '0; b_data = '0; out_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #4 rst_n = 1'b1;
        cyc();
    endtask

    task automatic check_seq(input string name);
        chk({name, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            chk($sformatf("%s_beat%0d", name, i), got[i], exp_q[i]);
    endtask

    // Drives queued beats like two ready/valid sources; out_ready low for cycles [stall_lo, stall_hi].
    task automatic run_streams(input string name, input int stall_lo, input int stall_hi);
        int ai = 0, bi = 0, n = 0;
        logic a_fire, b_fire, prev_hold = 1'b0;
        logic [15:0] prev_od = '0;
        hold_err = 0; b_early = 0; stall_seen = 0; trunc_n = 0; trunc_od = '0;
        got = {};
        while ((ai < qa_d.size() || bi < qb_d.size() || out_valid) && n < 300) begin
            a_valid = (ai < qa_d.size());
            a_data  = a_valid ? qa_d[ai] : '0;
            a_last  = a_valid ? qa_l[ai] : 1'b0;
            b_valid = (bi < qb_d.size());
            b_data  = b_valid ? qb_d[bi] : '0;
            b_last  = b_valid ? qb_l[bi] : 1'b0;
            out_ready = !(n >= stall_lo && n <= stall_hi);
            @(negedge clk);
            if (prev_hold && (out_data !== prev_od || out_valid !== 1'b1)) hold_err++;
            if (out_valid && !out_ready && (a_ready || b_ready)) hold_err++;
            if (a_ready && b_ready) hold_err++;
            if (b_ready && ai < qa_d.size()) b_early++;
            if (out_valid && !out_ready) stall_seen++;
            if (trunc) begin
                trunc_n++;
                trunc_od = out_data;
            end
            a_fire = a_valid & a_ready;
            b_fire = b_valid & b_ready;
            prev_hold = out_valid & ~out_ready;
            prev_od = out_data;
            cyc();
            if (a_fire) ai++;
            if (b_fire) bi++;
            n++;
        end
        chk({name, "_finished"}, (n < 300), 1);
        a_valid = 1'b0; b_valid = 1'b0;
        chk({name, "_hold_err"}, hold_err, 0);
    endtask

    initial begin
        // Asynchronous reset before any clock edge
        #1 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_sel", sel, 0);
        chk("rst_trunc", trunc, 0);
        chk("rst_a_ready", a_ready, 0);
        chk("rst_b_ready", b_ready, 0);

        // Both requesters valid with single-beat bursts: alternating grants
        vecs[0] = '{1, 16'h1111, 1, 1, 16'h2222, 1, 1,  0, 0, 0, 0, 16'h0000, 0};
        vecs[1] = '{1, 16'h1111, 1, 1, 16'h2222, 1, 1,  1, 0, 0, 0, 16'h0000, 0};
        vecs[2] = '{1, 16'h1111, 1, 1, 16'h2222, 1, 1,  0, 0, 0, 1, 16'h1111, 0};
        vecs[3] = '{1, 16'h1111, 1, 1, 16'h2222, 1, 1,  0, 1, 1, 0, 16'h1111, 0};
        vecs[4] = '{1, 16'h1111, 1, 1, 16'h2222, 1, 1,  0, 0, 1, 1, 16'h2222, 0};
        vecs[5] = '{1, 16'h1111, 1, 1, 16'h2222, 1, 1,  1, 0, 0, 0, 16'h2222, 0};
        vecs[6] = '{1, 16'h1111, 1, 1, 16'h2222, 1, 1,  0, 0, 0, 1, 16'h1111, 0};

        do_reset();
        for (int i = 0; i < 7; i++) begin
            a_valid = vecs[i].av; a_data = vecs[i].ad; a_last = vecs[i].al;
            b_valid = vecs[i].bv; b_data = vecs[i].bd; b_last = vecs[i].bl;
            out_ready = vecs[i].ordy;
            @(negedge clk);
            chk($sformatf("v%0d_a_ready", i), a_ready, vecs[i].ea);
            chk($sformatf("v%0d_b_ready", i), b_ready, vecs[i].eb);
            chk($sformatf("v%0d_sel", i), sel, vecs[i].es);
            chk($sformatf("v%0d_out_valid", i), out_valid, vecs[i].eov);
            chk($sformatf("v%0d_out_data", i), out_data, vecs[i].eod);
            chk($sformatf("v%0d_trunc", i), trunc, vecs[i].etr);
            cyc();
        end

        // 3-beat A burst while B waits
        do_reset();
        qa_d = {16'h0001, 16'h0002, 16'h0003}; qa_l = {1'b0, 1'b0, 1'b1};
        qb_d = {16'h00B1}; qb_l = {1'b1};
        run_streams("burst3", -1, -1);
        exp_q = {16'h0001, 16'h0002, 16'h0003, 16'h00B1};
        check_seq("burst3");
        chk("burst3_b_early", b_early, 0);

        // Downstream stall for 4 cycles mid-burst
        do_reset();
        qa_d = {16'h0A01, 16'h0A02, 16'h0A03, 16'h0A04}; qa_l = {1'b0, 1'b0, 1'b0, 1'b1};
        qb_d = {}; qb_l = {};
        run_streams("stall", 3, 6);
        exp_q = {16'h0A01, 16'h0A02, 16'h0A03, 16'h0A04};
        check_seq("stall");
        chk("stall_cycles_held", stall_seen, 4);

        // 17 A beats without last: forced release after beat 16, B served, then A's 17th
        do_reset();
        qa_d = {}; qa_l = {}; exp_q = {};
        for (int i = 1; i <= 17; i++) begin
            qa_d.push_back(16'h0A00 + 16'(i));
            qa_l.push_back(i == 17);
        end
        qb_d = {16'h0B01}; qb_l = {1'b1};
        run_streams("trunc", -1, -1);
        for (int i = 1; i <= 16; i++) exp_q.push_back(16'h0A00 + 16'(i));
        exp_q.push_back(16'h0B01);
        exp_q.push_back(16'h0A11);
        check_seq("trunc");
        chk("trunc_pulses", trunc_n, 1);
        chk("trunc_after_beat16", trunc_od, 16'h0A10);

        // last on the 16th beat is a normal end
        do_reset();
        qa_d = {}; qa_l = {}; exp_q = {};
        for (int i = 1; i <= 16; i++) begin
            qa_d.push_back(16'h0C00 + 16'(i));
            qa_l.push_back(i == 16);
            exp_q.push_back(16'h0C00 + 16'(i));
        end
        qb_d = {16'h0D01}; qb_l = {1'b1};
        exp_q.push_back(16'h0D01);
        run_streams("last16", -1, -1);
        check_seq("last16");
        chk("last16_no_trunc", trunc_n, 0);
        chk("last16_b_early", b_early, 0);

        // Asynchronous reset mid-B-burst with rr pointing at B
        do_reset();
        a_valid = 1'b1; a_data = 16'h1234; a_last = 1'b1; out_ready = 1'b1;
        cyc();
        cyc();
        a_valid = 1'b0; b_valid = 1'b1; b_data = 16'h5678; b_last = 1'b0; out_ready = 1'b0;
        cyc();
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        #1;
        chk("pre_rst_sel", sel, 1);
        chk("pre_rst_out_data", out_data, 16'h5678);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_data", out_data, 0);
        chk("mid_rst_sel", sel, 0);
        chk("mid_rst_b_ready", b_ready, 0);
        chk("mid_rst_a_ready", a_ready, 0);
        chk("mid_rst_trunc", trunc, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        a_valid = 1'b1; a_data = 16'hAAAA; a_last = 1'b1;
        b_valid = 1'b1; b_data = 16'hBBBB; b_last = 1'b1;
        out_ready = 1'b1;
        cyc();
        chk("post_rst_a_ready", a_ready, 1);
        chk("post_rst_b_ready", b_ready, 0);
        chk("post_rst_sel", sel, 0);
        cyc();
        chk("post_rst_out_valid", out_valid, 1);
        chk("post_rst_out_data", out_data, 16'hAAAA);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux2way16_arbiter.md
MUX2WAY16_ARBITER -- requirements
Module: mux2way16_arbiter

Interface
REQ-001 SHALL have parameter MAX_BURST, default 16: maximum number of beats per grant before a forced release.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have ports a_valid / b_valid, input, 1 bit each: requester A / B has a beat offered.
REQ-005 SHALL have ports a_data / b_data, input, 16 bits each: requester A / B beat data.
REQ-006 SHALL have ports a_last / b_last, input, 1 bit each: the offered beat ends the requester's burst.
REQ-007 SHALL have ports a_ready / b_ready, output, 1 bit each: the beat is accepted this cycle.
REQ-008 SHALL have port sel, output, 1 bit: select for the shared Mux2way16 path; 0 = A, 1 = B.
REQ-009 SHALL have ports out_valid, output, 1 bit, and out_data, output, 16 bits: registered shared-bus beat.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream accepts out_data this cycle.
REQ-011 SHALL have port trunc, output, 1 bit: one-cycle pulse when a burst is force-released at MAX_BURST.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY_A and BUSY_B.
REQ-013 In IDLE, SHALL grant on the next edge:
- only one valid: that requester
- both valid: the requester indicated by the round-robin pointer rr (0 = A first)
- neither valid: remain in IDLE
REQ-014 SHALL drive sel = 1 only in BUSY_B; sel SHALL hold its last value in IDLE.
REQ-015 Transfer condition: x_ready = (state == BUSY_x) & (~out_valid | out_ready); a beat transfers when x_valid & x_ready.
REQ-016 The non-granted requester's ready SHALL be 0.
REQ-017 On transfer, SHALL register out_data <= mux(a_data, b_data, sel) and set out_valid = 1 on the next edge.
REQ-018 SHALL clear out_valid when out_ready = 1 and no new transfer occurs in the same cycle; a simultaneous drain and refill SHALL keep out_valid = 1 with the new data.
REQ-019 SHALL hold out_data and out_valid stable while out_valid = 1 and out_ready = 0.
REQ-020 Latency: valid presented in IDLE at cycle N -> grant at N+1 -> out_valid at N+2 if out_ready is held high.
REQ-021 SHALL count beats in a 5-bit counter beat_cnt, cleared on every grant.
REQ-022 Burst end: a transfer with last = 1 -> IDLE; rr <= opposite of the requester just served.
REQ-023 Forced release: a transfer without last that makes beat_cnt == MAX_BURST -> IDLE, rr flips, trunc pulses for 1 cycle.
REQ-024 last = 1 on the MAX_BURST-th beat SHALL count as a normal end and SHALL NOT pulse trunc.
REQ-025 The granted requester deasserting valid mid-burst SHALL keep the grant; no timeout.
REQ-026 Grant SHALL never change while in BUSY_A or BUSY_B except through REQ-022 or REQ-023.

Reset
REQ-027 On rst_n = 0, SHALL immediately set state = IDLE, rr = 0, sel = 0, beat_cnt = 0, out_valid = 0, out_data = 0, trunc = 0, a_ready = 0, b_ready = 0.
REQ-028 Reset asserted mid-burst SHALL discard the in-flight output beat; the first grant after release SHALL follow REQ-013 with rr = 0.

Verification
REQ-029 Bench SHALL cover these directed scenarios:
- Both valid from reset, a_data = 0x1111, b_data = 0x2222, 1-beat bursts, out_ready = 1 -> out_data sequence 0x1111, 0x2222, 0x1111; sel toggles.
- A 3-beat burst 0x0001..0x0003 with b_valid held -> all three A beats appear before any B beat; b_ready = 0 throughout.
- out_ready = 0 for 4 cycles mid-burst -> out_data is held; a_ready = 0; no beat is lost or duplicated.
- A streams 17 beats with no last, MAX_BURST = 16 -> trunc pulses after beat 16; B is granted next; A's 17th beat follows B's burst.
- A beat 16 with last = 1 -> no trunc pulse.
- rst_n pulsed low asynchronously between clock edges mid-burst -> outputs cleared immediately; the next grant goes to A when both are valid.
